// File: rtl/button_press_gen_pkg.sv
// Shared types and constants for the button press generator and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_press_gen_pkg;

    // FSM state encoding, fixed so benches and debug views agree on values.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        HOLD   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int HOLD_W_DEF     = 8;
    localparam int BOUNCE_LEN_DEF = 2;  // also used by the button shaper bench
    localparam int GAP_CYCLES_DEF = 4;  // also used by the button shaper bench

    // Number of bounce segments for a given number of bounce pairs.
    function automatic logic [3:0] bounce_segs(input logic [2:0] pairs);
        return {pairs, 1'b0};
    endfunction

endpackage

// File: rtl/button_press_gen_if.sv
// Request/response bundle between a press requester and the press generator.
// Latency: n/a (wiring only).
// Backpressure: none; extra requests are buffered one deep or dropped by the generator.
interface button_press_gen_if #(
    parameter int HOLD_W = 8
);
    logic              req_in;
    logic [HOLD_W-1:0] hold_in;
    logic [2:0]        bounce_in;
    logic              b_out;
    logic              busy_out;
    logic              done_out;
    logic              overrun_out;

    modport master (
        output req_in, hold_in, bounce_in,
        input  b_out, busy_out, done_out, overrun_out
    );

    modport slave (
        input  req_in, hold_in, bounce_in,
        output b_out, busy_out, done_out, overrun_out
    );
endinterface

// File: rtl/button_press_gen.sv
// Turns a one-cycle request into an active-low press: optional bounce, steady hold, release gap.
// Latency: request sampled at edge k drives b_out low after edge k+1.
// Backpressure: one-deep pending slot while busy; a request arriving with the slot full is dropped and flagged.
module button_press_gen
    import button_press_gen_pkg::*;
#(
    parameter int HOLD_W     = HOLD_W_DEF,
    parameter int BOUNCE_LEN = BOUNCE_LEN_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rts,
    button_press_gen_if.slave bus
);

    localparam logic [HOLD_W-1:0] BNC_RELOAD = HOLD_W'(BOUNCE_LEN - 1);
    localparam logic [HOLD_W-1:0] GAP_RELOAD = HOLD_W'(GAP_CYCLES - 1);

    // A hold length of 0 behaves as 1, so the reload value saturates at 0.
    function automatic logic [HOLD_W-1:0] hold_reload(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : h - HOLD_W'(1);
    endfunction

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [3:0]        seg, seg_nxt;
    logic [HOLD_W-1:0] hold_q, hold_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic [HOLD_W-1:0] pend_hold, pend_hold_nxt;
    logic [2:0]        pend_bnc, pend_bnc_nxt;

    logic              start;
    logic [HOLD_W-1:0] start_hold;
    logic [2:0]        start_bnc;
    logic              consume;
    logic              ovr;
    logic              b_val;

    // State, counters and pending slot registers.
    always_ff @(posedge clk) begin
        if (rts) begin
            state     <= IDLE;
            cnt       <= '0;
            seg       <= '0;
            hold_q    <= '0;
            pend_vld  <= 1'b0;
            pend_hold <= '0;
            pend_bnc  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            seg       <= seg_nxt;
            hold_q    <= hold_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_hold <= pend_hold_nxt;
            pend_bnc  <= pend_bnc_nxt;
        end
    end

    // Next-state, counter reloads, pending-slot bookkeeping and output values.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        seg_nxt       = seg;
        hold_nxt      = hold_q;
        pend_vld_nxt  = pend_vld;
        pend_hold_nxt = pend_hold;
        pend_bnc_nxt  = pend_bnc;
        start         = 1'b0;
        start_hold    = bus.hold_in;
        start_bnc     = bus.bounce_in;
        ovr           = 1'b0;
        b_val         = 1'b1;
        consume       = (state == GAP) && (cnt == '0);

        case (state)
            IDLE: begin
                b_val = 1'b1;
                start = bus.req_in;
            end
            BOUNCE: begin
                // Segments count down from 2n-1; odd segments are low, so the
                // first is low and the last (segment 0) is high.
                b_val = ~seg[0];
                if (cnt == '0) begin
                    if (seg == 4'd0) begin
                        state_nxt = HOLD;
                        cnt_nxt   = hold_reload(hold_q);
                    end else begin
                        seg_nxt = seg - 4'd1;
                        cnt_nxt = BNC_RELOAD;
                    end
                end else begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end
            end
            HOLD: begin
                b_val = 1'b0;
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_RELOAD;
                end else begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end
            end
            GAP: begin
                b_val = 1'b1;
                if (cnt == '0) begin
                    if (pend_vld) begin
                        // Serve the slot and refill it with a same-cycle request.
                        start         = 1'b1;
                        start_hold    = pend_hold;
                        start_bnc     = pend_bnc;
                        pend_vld_nxt  = bus.req_in;
                        pend_hold_nxt = bus.hold_in;
                        pend_bnc_nxt  = bus.bounce_in;
                    end else if (bus.req_in) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Requests during a press go to the slot, or are dropped when it is full.
        if ((state != IDLE) && !consume && bus.req_in) begin
            if (pend_vld) begin
                ovr = 1'b1;
            end else begin
                pend_vld_nxt  = 1'b1;
                pend_hold_nxt = bus.hold_in;
                pend_bnc_nxt  = bus.bounce_in;
            end
        end

        if (start) begin
            hold_nxt = start_hold;
            if (start_bnc != 3'd0) begin
                state_nxt = BOUNCE;
                seg_nxt   = bounce_segs(start_bnc) - 4'd1;
                cnt_nxt   = BNC_RELOAD;
            end else begin
                state_nxt = HOLD;
                cnt_nxt   = hold_reload(start_hold);
            end
        end
    end

    // Registered outputs, one cycle behind the state they describe.
    always_ff @(posedge clk) begin
        if (rts) begin
            bus.b_out       <= 1'b1;
            bus.busy_out    <= 1'b0;
            bus.done_out    <= 1'b0;
            bus.overrun_out <= 1'b0;
        end else begin
            bus.b_out       <= b_val;
            bus.busy_out    <= (state != IDLE);
            bus.done_out    <= consume;
            bus.overrun_out <= ovr;
        end
    end

endmodule

// File: tb/tb_button_press_gen.sv
// Self-checking bench for button_press_gen: directed scenarios plus randomized traffic vs a waveform-queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_press_gen;
    import button_press_gen_pkg::*;

    localparam int HW  = 8;
    localparam int BL  = BOUNCE_LEN_DEF;
    localparam int GAP = GAP_CYCLES_DEF;

    logic clk = 1'b0;
    logic rts;
    int   checks = 0;
    int   passes = 0;

    button_press_gen_if #(.HOLD_W(HW)) bus ();

    button_press_gen #(.HOLD_W(HW), .BOUNCE_LEN(BL), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rts (rts),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted press appends its whole b_out waveform to a queue;
    // the queue head is the press cycle currently in progress.
    bit wave[$];
    bit pend_v;
    int pend_h, pend_n;
    bit exp_b = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_ovr = 1'b0;
    bit nxt_b = 1'b1, nxt_busy = 1'b0, nxt_done = 1'b0;

    task automatic add_press(input int h, input int n);
        for (int s = 0; s < 2 * n; s++)
            for (int j = 0; j < BL; j++) wave.push_back(bit'(s % 2));
        for (int j = 0; j < ((h == 0) ? 1 : h); j++) wave.push_back(1'b0);
        for (int j = 0; j < GAP; j++) wave.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        bit is_last;
        if (rts) begin
            wave.delete();
            pend_v = 1'b0;
            exp_b = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_ovr = 1'b0;
        end else begin
            exp_b = nxt_b; exp_busy = nxt_busy; exp_done = nxt_done; exp_ovr = 1'b0;
            if (wave.size() == 0) begin
                if (bus.req_in) add_press(int'(bus.hold_in), int'(bus.bounce_in));
            end else begin
                is_last = (wave.size() == 1);
                void'(wave.pop_front());
                if (is_last) begin
                    if (pend_v) begin
                        add_press(pend_h, pend_n);
                        pend_v = bus.req_in;
                        pend_h = int'(bus.hold_in);
                        pend_n = int'(bus.bounce_in);
                    end else if (bus.req_in) begin
                        add_press(int'(bus.hold_in), int'(bus.bounce_in));
                    end
                end else if (bus.req_in) begin
                    if (pend_v) exp_ovr = 1'b1;
                    else begin
                        pend_v = 1'b1;
                        pend_h = int'(bus.hold_in);
                        pend_n = int'(bus.bounce_in);
                    end
                end
            end
        end
        nxt_b    = (wave.size() != 0) ? wave[0] : 1'b1;
        nxt_busy = (wave.size() != 0);
        nxt_done = (wave.size() == 1);
    end

    // Behavioural stand-in for the downstream button shaper: one pulse once the
    // line has been low for longer than a bounce segment, re-armed after a stable release.
    int low_run = 0, high_run = 0;
    bit armed = 1'b1, shp_pulse = 1'b0;
    always @(posedge clk) begin
        if (bus.b_out == 1'b0) begin low_run++; high_run = 0; end
        else begin high_run++; low_run = 0; end
        shp_pulse = armed && (low_run == BL + 1);
        if (shp_pulse) armed = 1'b0;
        if (high_run >= BL + 1) armed = 1'b1;
    end

    // Drive one request at the next falling edge and clear it a cycle later.
    task automatic pulse_req(input int h, input int n);
        @(negedge clk);
        bus.req_in    = 1'b1;
        bus.hold_in   = HW'(h);
        bus.bounce_in = 3'(n);
        @(negedge clk);
        bus.req_in    = 1'b0;
    endtask

    task automatic test_reset();
        rts = 1'b1;
        bus.req_in = 1'b1; bus.hold_in = 8'd3; bus.bounce_in = 3'd1;
        repeat (3) @(negedge clk);
        checks++; if (bus.b_out !== 1'b1) $display("FAIL reset_b got %b want 1", bus.b_out); else passes++;
        checks++; if (bus.busy_out !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_out); else passes++;
        checks++; if (bus.done_out !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done_out); else passes++;
        checks++; if (bus.overrun_out !== 1'b0) $display("FAIL reset_ovr got %b want 0", bus.overrun_out); else passes++;
        bus.req_in = 1'b0;
        rts = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_press();
        int lows = 0, dones = 0;
        pulse_req(5, 0);
        checks++; if (bus.b_out !== 1'b1 || bus.busy_out !== 1'b0)
            $display("FAIL single_latency got b=%b busy=%b want b=1 busy=0", bus.b_out, bus.busy_out); else passes++;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (bus.b_out == 1'b0) lows++;
            if (bus.done_out) dones++;
            checks++; if (bus.b_out !== ((i <= 5) ? 1'b0 : 1'b1))
                $display("FAIL single_b cycle %0d got %b want %b", i, bus.b_out, (i <= 5) ? 1'b0 : 1'b1); else passes++;
            checks++; if (bus.busy_out !== (i <= 9))
                $display("FAIL single_busy cycle %0d got %b want %b", i, bus.busy_out, i <= 9); else passes++;
            checks++; if (bus.done_out !== (i == 9))
                $display("FAIL single_done cycle %0d got %b want %b", i, bus.done_out, i == 9); else passes++;
        end
        checks++; if (lows != 5) $display("FAIL single_lows got %0d want 5", lows); else passes++;
        checks++; if (dones != 1) $display("FAIL single_dones got %0d want 1", dones); else passes++;
    endtask

    task automatic test_bounce();
        bit pat[13] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
        int busy_cycles = 0;
        pulse_req(0, 2);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (bus.busy_out) busy_cycles++;
            checks++; if (bus.b_out !== ((i <= 13) ? pat[i-1] : 1'b1))
                $display("FAIL bounce_b cycle %0d got %b want %b", i, bus.b_out, (i <= 13) ? pat[i-1] : 1'b1); else passes++;
            checks++; if (bus.done_out !== (i == 13))
                $display("FAIL bounce_done cycle %0d got %b want %b", i, bus.done_out, i == 13); else passes++;
        end
        checks++; if (busy_cycles != 13) $display("FAIL bounce_busy_len got %0d want 13", busy_cycles); else passes++;
    endtask

    task automatic test_back_to_back();
        int dones = 0, ovrs = 0;
        bit want_b;
        pulse_req(3, 0);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            bus.req_in = 1'b0;
            want_b = !((i <= 3) || (i >= 8 && i <= 10));
            if (bus.done_out) dones++;
            if (bus.overrun_out) ovrs++;
            checks++; if (bus.b_out !== want_b)
                $display("FAIL b2b_b cycle %0d got %b want %b", i, bus.b_out, want_b); else passes++;
            checks++; if (bus.busy_out !== (i <= 14))
                $display("FAIL b2b_busy cycle %0d got %b want %b", i, bus.busy_out, i <= 14); else passes++;
            checks++; if (bus.overrun_out !== (i == 4))
                $display("FAIL b2b_ovr cycle %0d got %b want %b", i, bus.overrun_out, i == 4); else passes++;
            if (i == 1) begin bus.req_in = 1'b1; bus.hold_in = 8'd3; bus.bounce_in = 3'd0; end
            if (i == 3) begin bus.req_in = 1'b1; bus.hold_in = 8'd7; bus.bounce_in = 3'd1; end
        end
        checks++; if (dones != 2) $display("FAIL b2b_dones got %0d want 2", dones); else passes++;
        checks++; if (ovrs != 1) $display("FAIL b2b_ovrs got %0d want 1", ovrs); else passes++;
    endtask

    task automatic test_reset_mid();
        int lows = 0, dones = 0, busys = 0;
        pulse_req(8, 0);
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            bus.req_in = 1'b0;
            rts = 1'b0;
            if (i == 4) begin
                checks++; if (bus.b_out !== 1'b1 || bus.busy_out !== 1'b0)
                    $display("FAIL rstmid_now got b=%b busy=%b want b=1 busy=0", bus.b_out, bus.busy_out); else passes++;
            end
            if (i >= 4) begin
                if (bus.b_out == 1'b0) lows++;
                if (bus.busy_out) busys++;
                if (bus.done_out) dones++;
            end
            if (i == 1) begin bus.req_in = 1'b1; bus.hold_in = 8'd2; bus.bounce_in = 3'd0; end
            if (i == 3) rts = 1'b1;
        end
        checks++; if (lows != 0) $display("FAIL rstmid_lows got %0d want 0", lows); else passes++;
        checks++; if (busys != 0) $display("FAIL rstmid_busy got %0d want 0", busys); else passes++;
        checks++; if (dones != 0) $display("FAIL rstmid_dones got %0d want 0", dones); else passes++;
    endtask

    task automatic test_shaper();
        int pulses = 0, dones = 0;
        pulse_req(10, 3);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            bus.req_in = 1'b0;
            if (shp_pulse) pulses++;
            if (bus.done_out) dones++;
            if (i == 2) begin bus.req_in = 1'b1; bus.hold_in = 8'd10; bus.bounce_in = 3'd3; end
        end
        checks++; if (pulses != 2) $display("FAIL shaper_pulses got %0d want 2", pulses); else passes++;
        checks++; if (dones != 2) $display("FAIL shaper_dones got %0d want 2", dones); else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++; if (bus.b_out !== exp_b)
                $display("FAIL rand_b cycle %0d got %b want %b", i, bus.b_out, exp_b); else passes++;
            checks++; if (bus.busy_out !== exp_busy)
                $display("FAIL rand_busy cycle %0d got %b want %b", i, bus.busy_out, exp_busy); else passes++;
            checks++; if (bus.done_out !== exp_done)
                $display("FAIL rand_done cycle %0d got %b want %b", i, bus.done_out, exp_done); else passes++;
            checks++; if (bus.overrun_out !== exp_ovr)
                $display("FAIL rand_ovr cycle %0d got %b want %b", i, bus.overrun_out, exp_ovr); else passes++;
            bus.req_in    = ($urandom_range(0, 5) == 0);
            bus.hold_in   = HW'($urandom_range(0, 6));
            bus.bounce_in = 3'($urandom_range(0, 3));
            rts           = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        bus.req_in = 1'b0;
        rts = 1'b0;
    endtask

    initial begin
        rts = 1'b1;
        bus.req_in = 1'b0;
        bus.hold_in = '0;
        bus.bounce_in = '0;
        test_reset();
        test_single_press();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        test_shaper();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_press_gen.md
# button_press_gen

Drives an active-low, button-style line from a one-cycle request pulse. This is the inverse of the button shaper, which turns a held press into a single pulse. The block stretches a request into a held press of programmable length, optionally preceded by contact-bounce toggles, and follows it with a mandatory release gap. It sits in front of the button shaper in self-test and demo builds, standing in for the physical push-buttons of the number-matching game. Its output drops straight onto the shaper's button input.

## Interface

Parameters:
- HOLD_W, 8: width of the hold-length request field.
- BOUNCE_LEN, 2: cycles per bounce segment (≥1).
- GAP_CYCLES, 4: released (high) cycles enforced after every press (≥1).

Ports:
- Clk, in, 1: system clock. All logic is on the rising edge.
- rts, in, 1: reset. Synchronous and active-high.
- Req_in, in, 1: one-cycle press request.
- Hold_in, in, HOLD_W: number of low cycles in the steady hold. Sampled with Req_in. A value of 0 is treated as 1.
- Bounce_in, in, 3: number of bounce pairs, 0–7. Sampled with Req_in.
- B_out, out, 1: emulated button, active-low. Idle is 1.
- Busy_out, out, 1: high whenever the FSM is not in IDLE.
- Done_out, out, 1: one-cycle pulse when a press, including its gap, completes.
- Overrun_out, out, 1: one-cycle pulse when a request is dropped.

## Operation

- FSM states: IDLE, BOUNCE, HOLD, GAP. State is encoded in 2 bits.
- IDLE
  - B_out=1.
  - When Req_in=1, capture Hold_in and Bounce_in.
  - Go to BOUNCE if the captured bounce count is nonzero, otherwise go to HOLD.
- BOUNCE
  - Lasts 2·n segments, where n is the captured bounce count.
  - Each segment is BOUNCE_LEN cycles.
  - B_out alternates 0,1,0,1,… starting with 0.
  - After the last segment, which is high, go to HOLD.
- HOLD
  - B_out=0 for max(Hold_in,1) cycles, then go to GAP.
- GAP
  - B_out=1 for GAP_CYCLES cycles.
  - On the final GAP cycle, Done_out=1.
  - If a request is pending, go directly to BOUNCE/HOLD using the pending fields. Otherwise go to IDLE.
- Pending slot (one deep)
  - Req_in while Busy_out=1 and the slot is empty: store Hold_in/Bounce_in and set pending.
  - Req_in while the slot is full: drop the request and pulse Overrun_out the next cycle. The pending contents are unchanged.
  - If a Req_in arrives in the same cycle the slot is consumed (final GAP cycle), the slot is refilled with the new request. No overrun occurs.
- Counters
  - One down-counter, HOLD_W bits, shared by all states and reloaded on every state or segment entry.
  - One 4-bit segment counter for BOUNCE.
  - No wrap: counters reload, they never roll over.
- All outputs are registered.

## Timing

- Reset values: B_out=1, Busy_out=0, Done_out=0, Overrun_out=0, state=IDLE, pending cleared.
- Reset mid-press forces B_out=1 on the next edge. There is no Done_out and any pending request is lost.
- Latency: Req_in sampled at edge k gives B_out=0 and Busy_out=1 after edge k+1.
- Length of one press, from first low to Done_out, is 2·n·BOUNCE_LEN + max(H,1) + GAP_CYCLES cycles.
  - Done_out is high during the last gap cycle.
  - Busy_out drops the cycle after that, unless a pending request continues.
- Back-to-back pending service: B_out goes low in the cycle immediately after Done_out. The minimum high time between presses is therefore exactly GAP_CYCLES.
- Req_in held high for several cycles counts as several requests. The source must pulse.
- rts has priority over Req_in in the same cycle.

## Structure

- Shared package holds:
  - the state typedef/localparams (IDLE=0, BOUNCE=1, HOLD=2, GAP=3);
  - the default BOUNCE_LEN and GAP_CYCLES constants, which the button shaper bench also uses.
- Keep the block flat, in a single module. The pending slot is small enough to stay inline, so no sub-module is needed.

## Test plan

- Reset, then Req_in with Hold_in=5 and Bounce_in=0:
  - B_out low for exactly 5 cycles starting at edge k+1;
  - B_out high for 4 cycles;
  - Done_out pulses once, then Busy_out=0.
- Hold_in=0 and Bounce_in=2 with BOUNCE_LEN=2:
  - B_out pattern 00 11 00 11 then 0 (1 cycle), then 1111;
  - total of 13 cycles busy.
- Second Req_in during HOLD (Hold_in=3), third during the same press:
  - second press starts the cycle after Done_out;
  - Overrun_out pulses once for the third;
  - exactly two Done_out pulses.
- Assert rts mid-HOLD with a request pending:
  - B_out=1 and Busy_out=0 next edge;
  - no Done_out, and no later press.
- Wire B_out into the button shaper, then Req_in with Hold_in=10 and Bounce_in=3:
  - the shaper output shows exactly one single-cycle pulse per press.
